// File: rtl/matrix_mult_core_nxn.sv
// matrix_mult_core_nxn
// N x N signed matrix multiplier on the Red Pitaya system register bus.
// Software writes A and B, sets SHIFT, strobes START, polls STATUS and then
// reads C = sat32((A*B) >>> SHIFT).  One MAC unit performs one multiply per
// clock, so a full product takes N^3 cycles with no gaps between elements.
//
// Ports
//   system1000       clock
//   system1000_rstn  asynchronous active-low reset
//   sys_addr         byte address (only [11:0] decoded)
//   sys_wdata        write data
//   sys_wen/sys_ren  single-cycle write/read strobes
//   sys_rdata        read data, valid with sys_ack
//   sys_ack          registered acknowledge, one cycle after the strobe
//   sys_err          transfer error, qualified by sys_ack
//
// state | meaning
// IDLE  | waiting for START; bus may freely change A, B, SHIFT
// RUN   | one MAC per cycle over i/j/k; A, B, SHIFT are write-protected
module matrix_mult_core_nxn #(
    parameter int N  = 3,
    parameter int DW = 16
) (
    input  logic        system1000,
    input  logic        system1000_rstn,
    input  logic [31:0] sys_addr,
    input  logic [31:0] sys_wdata,
    input  logic        sys_wen,
    input  logic        sys_ren,
    output logic [31:0] sys_rdata,
    output logic        sys_ack,
    output logic        sys_err
);

    localparam int NN  = N * N;
    localparam int IXW = $clog2(NN);
    localparam int IW  = $clog2(N);
    localparam int PW  = 2 * DW;
    // Wide enough that N products of PW bits can never overflow.
    localparam int AW  = 2 * DW + $clog2(N) + 1;

    localparam logic [IW-1:0]      LAST  = IW'(N - 1);
    localparam logic [6:0]         NN_W  = 7'(NN);
    localparam logic signed [63:0] MAX32 = 64'sh0000_0000_7FFF_FFFF;
    localparam logic signed [63:0] MIN32 = -64'sh0000_0000_8000_0000;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic signed [DW-1:0] a_mem [NN];
    logic signed [DW-1:0] b_mem [NN];
    logic [31:0]          c_mem [NN];
    logic [5:0]           shift_q;
    logic                 done_q;
    logic                 ovf_q;
    logic [IW-1:0]        i_q, j_q, k_q;
    logic signed [AW-1:0] acc_q;
    logic                 busy;

    // ---------------- bus decode ----------------
    logic [11:0]    off;
    logic [5:0]     widx;
    logic [IXW-1:0] midx;
    logic           idx_ok;
    logic           sel_ctrl, sel_status, sel_shift, sel_a, sel_b, sel_c;

    assign busy       = (state_q == RUN);
    assign off        = sys_addr[11:0];
    assign widx       = off[7:2];
    assign midx       = IXW'(widx);
    assign idx_ok     = (off[1:0] == 2'b00) && ({1'b0, widx} < NN_W);
    assign sel_ctrl   = (off == 12'h000);
    assign sel_status = (off == 12'h004);
    assign sel_shift  = (off == 12'h008);
    assign sel_a      = (off[11:8] == 4'h1) && idx_ok;
    assign sel_b      = (off[11:8] == 4'h2) && idx_ok;
    assign sel_c      = (off[11:8] == 4'h3) && idx_ok;

    logic [31:0] rd_val;
    logic        rd_err;
    logic        wr_err;

    always_comb begin
        rd_val = '0;
        rd_err = 1'b0;
        if (sel_ctrl) begin
            rd_val = '0;
        end else if (sel_status) begin
            rd_val = {29'b0, ovf_q, done_q, busy};
        end else if (sel_shift) begin
            rd_val = {26'b0, shift_q};
        end else if (sel_a) begin
            rd_val = {{(32-DW){a_mem[midx][DW-1]}}, a_mem[midx]};
        end else if (sel_b) begin
            rd_val = {{(32-DW){b_mem[midx][DW-1]}}, b_mem[midx]};
        end else if (sel_c) begin
            rd_val = c_mem[midx];
        end else begin
            rd_err = 1'b1;
        end
    end

    always_comb begin
        wr_err = 1'b1;
        if (sel_ctrl) begin
            wr_err = 1'b0;
        end else if (sel_shift || sel_a || sel_b) begin
            wr_err = busy;
        end
    end

    logic wr_ok, ctrl_start, ctrl_clear;
    assign wr_ok      = sys_wen && !wr_err;
    // CTRL writes while busy are acked cleanly but have no effect.
    assign ctrl_start = sys_wen && sel_ctrl && !busy && sys_wdata[0];
    assign ctrl_clear = sys_wen && sel_ctrl && !busy && sys_wdata[1];

    // ---------------- MAC datapath ----------------
    logic [IXW-1:0]       a_idx, b_idx, c_idx;
    logic signed [PW-1:0] a_ext, b_ext, prod;
    logic signed [AW-1:0] sum, shifted;
    logic signed [63:0]   sh64;
    logic [31:0]          sat_val;
    logic                 clamp;
    logic                 elem_done, last_mac;

    assign a_idx     = IXW'(int'(i_q) * N + int'(k_q));
    assign b_idx     = IXW'(int'(k_q) * N + int'(j_q));
    assign c_idx     = IXW'(int'(i_q) * N + int'(j_q));
    assign a_ext     = PW'(a_mem[a_idx]);
    assign b_ext     = PW'(b_mem[b_idx]);
    assign prod      = a_ext * b_ext;
    assign sum       = acc_q + AW'(prod);
    assign shifted   = sum >>> shift_q;
    assign sh64      = 64'(shifted);
    assign elem_done = (k_q == LAST);
    assign last_mac  = elem_done && (i_q == LAST) && (j_q == LAST);

    always_comb begin
        sat_val = sh64[31:0];
        clamp   = 1'b0;
        if (sh64 > MAX32) begin
            sat_val = 32'h7FFF_FFFF;
            clamp   = 1'b1;
        end else if (sh64 < MIN32) begin
            sat_val = 32'h8000_0000;
            clamp   = 1'b1;
        end
    end

    // ---------------- engine FSM ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ctrl_start) state_d = RUN;
            RUN:     if (last_mac)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            for (int x = 0; x < NN; x++) begin
                a_mem[x] <= '0;
                b_mem[x] <= '0;
                c_mem[x] <= '0;
            end
            shift_q   <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            acc_q     <= '0;
            sys_ack   <= 1'b0;
            sys_err   <= 1'b0;
            sys_rdata <= '0;
        end else begin
            // Read data is taken before this cycle's write lands, so a
            // simultaneous wen+ren returns the old value.
            sys_ack   <= sys_wen || sys_ren;
            sys_err   <= (sys_wen && wr_err) || (sys_ren && rd_err);
            sys_rdata <= sys_ren ? rd_val : '0;

            if (wr_ok) begin
                if (sel_shift) shift_q <= sys_wdata[5:0];
                if (sel_a)     a_mem[midx] <= sys_wdata[DW-1:0];
                if (sel_b)     b_mem[midx] <= sys_wdata[DW-1:0];
            end

            if (ctrl_clear) begin
                for (int x = 0; x < NN; x++) c_mem[x] <= '0;
                done_q <= 1'b0;
                ovf_q  <= 1'b0;
            end

            if (ctrl_start) begin
                i_q    <= '0;
                j_q    <= '0;
                k_q    <= '0;
                acc_q  <= '0;
                done_q <= 1'b0;
            end

            if (state_q == RUN) begin
                if (!elem_done) begin
                    acc_q <= sum;
                    k_q   <= k_q + IW'(1);
                end else begin
                    c_mem[c_idx] <= sat_val;
                    if (clamp) ovf_q <= 1'b1;
                    acc_q <= '0;
                    k_q   <= '0;
                    if (j_q == LAST) begin
                        j_q <= '0;
                        i_q <= (i_q == LAST) ? '0 : i_q + IW'(1);
                    end else begin
                        j_q <= j_q + IW'(1);
                    end
                    if (last_mac) done_q <= 1'b1;
                end
            end
        end
    end

    // Address bits above [11:0] are decoded upstream; high data bits are
    // don't-care for every register.
    logic unused_bits;
    assign unused_bits = &{1'b0, sys_addr[31:12], sys_wdata[31:DW]};

endmodule

// File: tb/tb_matrix_mult_core_nxn.sv
module tb_matrix_mult_core_nxn;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] addr0 = '0, wdata0 = '0, rdata0;
    logic        wen0 = 1'b0, ren0 = 1'b0, ack0, err0;
    logic [31:0] addr1 = '0, wdata1 = '0, rdata1;
    logic        wen1 = 1'b0, ren1 = 1'b0, ack1, err1;

    matrix_mult_core_nxn #(.N(3), .DW(16)) dut3 (
        .system1000(clk), .system1000_rstn(rstn),
        .sys_addr(addr0), .sys_wdata(wdata0), .sys_wen(wen0), .sys_ren(ren0),
        .sys_rdata(rdata0), .sys_ack(ack0), .sys_err(err0)
    );

    matrix_mult_core_nxn #(.N(4), .DW(16)) dut4 (
        .system1000(clk), .system1000_rstn(rstn),
        .sys_addr(addr1), .sys_wdata(wdata1), .sys_wen(wen1), .sys_ren(ren1),
        .sys_rdata(rdata1), .sys_ack(ack1), .sys_err(err1)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   ma [64];
    int   mb [64];
    int   mshift = 0;
    logic m_ovf = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic set_bus(input int d, input logic w, input logic r,
                           input logic [31:0] a, input logic [31:0] wd);
        if (d == 0) begin
            wen0 = w; ren0 = r; addr0 = a; wdata0 = wd;
        end else begin
            wen1 = w; ren1 = r; addr1 = a; wdata1 = wd;
        end
    endtask

    task automatic get_resp(input int d, output logic [31:0] rd, output logic er, output logic ak);
        if (d == 0) begin
            rd = rdata0; er = err0; ak = ack0;
        end else begin
            rd = rdata1; er = err1; ak = ack1;
        end
    endtask

    task automatic xfer(input int d, input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output logic ak);
        @(negedge clk);
        set_bus(d, w, r, a, wd);
        @(negedge clk);
        get_resp(d, rd, er, ak);
        set_bus(d, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic wr(input int d, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] rd;
        logic er, ak;
        xfer(d, 1'b1, 1'b0, a, wd, rd, er, ak);
    endtask

    task automatic wr_chk(input int d, input logic [31:0] a, input logic [31:0] wd,
                          input logic exp_err, input string tag);
        logic [31:0] rd;
        logic er, ak;
        xfer(d, 1'b1, 1'b0, a, wd, rd, er, ak);
        check(tag, {30'b0, ak, er}, {30'b0, 1'b1, exp_err});
    endtask

    task automatic rd_chk(input int d, input logic [31:0] a, input logic [31:0] exp,
                          input logic exp_err, input string tag);
        logic [31:0] rd;
        logic er, ak;
        xfer(d, 1'b0, 1'b1, a, '0, rd, er, ak);
        check(tag, rd, exp);
        check({tag, "_ackerr"}, {30'b0, ak, er}, {30'b0, 1'b1, exp_err});
    endtask

    // Reference: C[r][c] = sat32((sum_k A[r][k]*B[k][c]) >>> shift); bit 32 flags a clamp.
    function automatic logic [32:0] model_c(input int n, input int r, input int c);
        longint s = 0;
        for (int k = 0; k < n; k++) s += longint'(ma[r*n+k]) * longint'(mb[k*n+c]);
        s = s >>> mshift;
        if (s > 64'sd2147483647)  return {1'b1, 32'h7FFF_FFFF};
        if (s < -64'sd2147483648) return {1'b1, 32'h8000_0000};
        return {1'b0, s[31:0]};
    endfunction

    task automatic load_mats(input int d, input int n);
        for (int x = 0; x < n*n; x++) begin
            wr(d, 32'h100 + 32'(4*x), 32'(ma[x]));
            wr(d, 32'h200 + 32'(4*x), 32'(mb[x]));
        end
        wr(d, 32'h008, 32'(mshift));
    endtask

    task automatic rand_mats(input int n);
        for (int x = 0; x < n*n; x++) begin
            ma[x] = int'($urandom_range(0, 65535)) - 32768;
            mb[x] = int'($urandom_range(0, 65535)) - 32768;
        end
    endtask

    task automatic check_c(input int d, input int n, input string tag);
        logic [32:0] m;
        for (int x = 0; x < n*n; x++) begin
            m = model_c(n, x / n, x % n);
            m_ovf = m_ovf | m[32];
            rd_chk(d, 32'h300 + 32'(4*x), m[31:0], 1'b0, $sformatf("%s_c%0d", tag, x));
        end
        rd_chk(d, 32'h004, {29'b0, m_ovf, 1'b1, 1'b0}, 1'b0, {tag, "_status"});
    endtask

    // Strobe CTRL, then strobe one transfer every cycle: STATUS reads, except
    // slot 'inj' which carries a write.  busy_cyc is the slot index of the
    // first STATUS read showing BUSY=0, i.e. the number of busy cycles.
    task automatic run_poll(input int d, input int n, input logic [31:0] ctrl,
                            input int inj, input logic [31:0] inj_a, input logic [31:0] inj_d,
                            output int busy_cyc, output logic inj_err);
        logic [31:0] rd;
        logic er, ak;
        busy_cyc = -1;
        inj_err  = 1'b0;
        xfer(d, 1'b1, 1'b0, 32'h000, ctrl, rd, er, ak);
        for (int p = 0; p < n*n*n + 20; p++) begin
            if (p == inj) set_bus(d, 1'b1, 1'b0, inj_a, inj_d);
            else          set_bus(d, 1'b0, 1'b1, 32'h004, '0);
            @(negedge clk);
            get_resp(d, rd, er, ak);
            if (p == inj) begin
                inj_err = er;
            end else if (rd[0] == 1'b0) begin
                busy_cyc = p;
                break;
            end
        end
        set_bus(d, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        logic [31:0] rd;
        logic er, ak, ie;
        int bc;

        repeat (3) @(negedge clk);
        rstn = 1'b1;

        // ---- reset state and register map ----
        rd_chk(0, 32'h004, 32'h0, 1'b0, "rst_status");
        rd_chk(0, 32'h008, 32'h0, 1'b0, "rst_shift");
        rd_chk(0, 32'h300, 32'h0, 1'b0, "rst_c00");
        rd_chk(0, 32'h010, 32'h0, 1'b1, "bad_off");
        rd_chk(0, 32'h102, 32'h0, 1'b1, "misaligned");
        rd_chk(0, 32'h000, 32'h0, 1'b0, "ctrl_rd");
        rd_chk(0, 32'h124, 32'h0, 1'b1, "a_idx9");
        wr_chk(0, 32'h004, 32'h1, 1'b1, "status_wr");
        wr_chk(0, 32'h300, 32'h1, 1'b1, "c_wr");
        xfer(0, 1'b1, 1'b1, 32'h008, 32'h5, rd, er, ak);
        check("wr_rd_old", rd, 32'h0);
        rd_chk(0, 32'h008, 32'h5, 1'b0, "shift_new");
        wr(0, 32'h104, 32'hFFFF_8001);
        rd_chk(0, 32'h104, 32'hFFFF_8001, 1'b0, "a_sext");

        // ---- directed 3x3 product ----
        for (int x = 0; x < 9; x++) begin
            ma[x] = x + 1;
            mb[x] = x + 1;
        end
        mshift = 0;
        load_mats(0, 3);
        run_poll(0, 3, 32'h1, -1, '0, '0, bc, ie);
        check("busy_len_prod", 32'(bc), 32'd27);
        check_c(0, 3, "prod");
        rd_chk(0, 32'h300 + 4*8, 32'd150, 1'b0, "prod_c22");

        // ---- saturation, then CLEAR and shifted rerun ----
        for (int x = 0; x < 9; x++) begin
            ma[x] = -32768;
            mb[x] = -32768;
        end
        load_mats(0, 3);
        run_poll(0, 3, 32'h1, -1, '0, '0, bc, ie);
        check("busy_len_sat", 32'(bc), 32'd27);
        check_c(0, 3, "sat");
        rd_chk(0, 32'h310, 32'h7FFF_FFFF, 1'b0, "sat_c11");
        wr_chk(0, 32'h000, 32'h2, 1'b0, "clear_wr");
        m_ovf = 1'b0;
        rd_chk(0, 32'h004, 32'h0, 1'b0, "clear_status");
        rd_chk(0, 32'h310, 32'h0, 1'b0, "clear_c11");
        mshift = 2;
        wr(0, 32'h008, 32'h2);
        run_poll(0, 3, 32'h1, -1, '0, '0, bc, ie);
        check_c(0, 3, "sat_sh2");
        rd_chk(0, 32'h300, 32'h3000_0000, 1'b0, "sh2_c00");

        // ---- busy protection ----
        rand_mats(3);
        mshift = int'($urandom_range(0, 20));
        load_mats(0, 3);
        run_poll(0, 3, 32'h1, 0, 32'h100, 32'h1234, bc, ie);
        check("busy_wr_err", {31'b0, ie}, 32'h1);
        check("busy_len_wr", 32'(bc), 32'd27);
        check_c(0, 3, "prot");
        rd_chk(0, 32'h100, 32'(ma[0]), 1'b0, "prot_a00");
        run_poll(0, 3, 32'h1, 5, 32'h000, 32'h1, bc, ie);
        check("restart_err", {31'b0, ie}, 32'h0);
        check("busy_len_restart", 32'(bc), 32'd27);
        run_poll(0, 3, 32'h1, 3, 32'h008, 32'h7, bc, ie);
        check("busy_shift_err", {31'b0, ie}, 32'h1);
        check_c(0, 3, "prot_shift");

        // ---- randomized runs with CLEAR+START together ----
        for (int it = 0; it < 4; it++) begin
            rand_mats(3);
            mshift = (it == 0) ? 0 : int'($urandom_range(0, 40));
            load_mats(0, 3);
            m_ovf = 1'b0;
            run_poll(0, 3, 32'h3, -1, '0, '0, bc, ie);
            check($sformatf("busy_len_rnd%0d", it), 32'(bc), 32'd27);
            check_c(0, 3, $sformatf("rnd%0d", it));
        end

        // ---- reset mid-run ----
        xfer(0, 1'b1, 1'b0, 32'h000, 32'h1, rd, er, ak);
        repeat (10) @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        m_ovf = 1'b0;
        for (int x = 0; x < 9; x++)
            rd_chk(0, 32'h300 + 32'(4*x), 32'h0, 1'b0, $sformatf("mid_rst_c%0d", x));
        rd_chk(0, 32'h004, 32'h0, 1'b0, "mid_rst_status");
        rd_chk(0, 32'h008, 32'h0, 1'b0, "mid_rst_shift");
        rd_chk(0, 32'h100, 32'h0, 1'b0, "mid_rst_a00");
        rand_mats(3);
        mshift = int'($urandom_range(0, 16));
        load_mats(0, 3);
        run_poll(0, 3, 32'h1, -1, '0, '0, bc, ie);
        check("busy_len_fresh", 32'(bc), 32'd27);
        check_c(0, 3, "fresh");

        // ---- N=4 instance ----
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                ma[r*4+c] = (r == c) ? 1 : 0;
                mb[r*4+c] = 16*r + c;
            end
        mshift = 0;
        m_ovf  = 1'b0;
        load_mats(1, 4);
        run_poll(1, 4, 32'h1, -1, '0, '0, bc, ie);
        check("busy_len_n4", 32'(bc), 32'd64);
        check_c(1, 4, "n4");
        rd_chk(1, 32'h300 + 4*13, 32'd49, 1'b0, "n4_c31");
        rd_chk(1, 32'h140, 32'h0, 1'b1, "n4_a16_rd");
        wr_chk(1, 32'h140, 32'h1, 1'b1, "n4_a16_wr");
        rd_chk(1, 32'h13C, 32'h1, 1'b0, "n4_a15");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
